// File: rtl/alu_mc_if.sv
// Handshake bundle for alu_mc: operand request channel and result channel.
// master drives in_valid/src1/src2/op/out_ready; slave returns the rest.
interface alu_mc_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             carry;

  modport master (
    output in_valid, src1, src2, op, out_ready,
    input  in_ready, out_valid, result, zero, overflow, carry
  );

  modport slave (
    input  in_valid, src1, src2, op, out_ready,
    output in_ready, out_valid, result, zero, overflow, carry
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/add/sub/slt, shift-add unsigned mul.
// Ports: clk, rst_n (async active-low), bus (alu_mc_if.slave).
module alu_mc #(
  parameter int WIDTH = 8
) (
  input logic     clk,
  input logic     rst_n,
  alu_mc_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;

  logic               sub;
  logic [WIDTH-1:0]   b_in;
  logic [WIDTH:0]     sum;
  logic               add_ovf;
  logic               slt;
  logic [WIDTH-1:0]   res_n;
  logic               ovf_n;
  logic               cry_n;
  logic [WIDTH:0]     upper;
  logic [2*WIDTH-1:0] prod_n;

  assign bus.in_ready = (state == IDLE);

  // SUB and SLT share the adder as src1 + ~src2 + 1
  assign sub  = (bus.op == OP_SUB) || (bus.op == OP_SLT);
  assign b_in = sub ? ~bus.src2 : bus.src2;
  assign sum  = {1'b0, bus.src1} + {1'b0, b_in}
              + {{WIDTH{1'b0}}, sub};

  assign add_ovf = (bus.src1[WIDTH-1] == b_in[WIDTH-1])
                && (sum[WIDTH-1] != bus.src1[WIDTH-1]);
  assign slt     = sum[WIDTH-1] ^ add_ovf;

  always_comb begin
    res_n = '0;
    ovf_n = 1'b0;
    cry_n = 1'b0;
    case (bus.op)
      OP_AND: res_n = bus.src1 & bus.src2;
      OP_OR:  res_n = bus.src1 | bus.src2;
      OP_NOR: res_n = ~(bus.src1 | bus.src2);
      OP_ADD, OP_SUB: begin
        res_n = sum[WIDTH-1:0];
        ovf_n = add_ovf;
        cry_n = sum[WIDTH];
      end
      OP_SLT: begin
        res_n = {{(WIDTH-1){1'b0}}, slt};
        cry_n = sum[WIDTH];
      end
      default: ;
    endcase
  end

  // prod = {partial, remaining multiplier}; LSB picks the add,
  // then the whole register shifts right by one
  assign upper  = prod[0]
                ? {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand}
                : {1'b0, prod[2*WIDTH-1:WIDTH]};
  assign prod_n = {upper, prod[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      mcand         <= '0;
      prod          <= '0;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.zero      <= 1'b1;
      bus.overflow  <= 1'b0;
      bus.carry     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.op == OP_MUL) begin
              mcand <= bus.src1;
              prod  <= {{WIDTH{1'b0}}, bus.src2};
              cnt   <= '0;
              state <= MUL;
            end else begin
              bus.result    <= res_n;
              bus.zero      <= (res_n == '0);
              bus.overflow  <= ovf_n;
              bus.carry     <= cry_n;
              bus.out_valid <= 1'b1;
              state         <= DONE;
            end
          end
        end
        MUL: begin
          prod <= prod_n;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            bus.result    <= prod_n[WIDTH-1:0];
            bus.zero      <= (prod_n[WIDTH-1:0] == '0);
            bus.overflow  <= |prod_n[2*WIDTH-1:WIDTH];
            bus.carry     <= 1'b0;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH=8.
// Drives and samples on the falling edge of clk.
module tb_alu_mc;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   lat;
  int   pulses;

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // issue one op, wait (bounded) for out_valid, check latency and outputs,
  // then consume the result and confirm return to idle
  task automatic run(input string tag, input logic [2:0] op,
                     input logic [7:0] a, input logic [7:0] b,
                     input int exp_lat, input logic [7:0] res,
                     input logic z, input logic o, input logic c);
    chk({tag, ".rdy"}, bus.in_ready, 1);
    bus.op = op;
    bus.src1 = a;
    bus.src2 = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".res"}, bus.result, res);
    chk({tag, ".flags"}, {bus.zero, bus.overflow, bus.carry}, {z, o, c});
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, ".idle"}, {bus.out_valid, bus.in_ready}, 2'b01);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = 3'b000;
    bus.src1 = '0;
    bus.src2 = '0;
    repeat (2) @(negedge clk);
    chk("rst.rdy", bus.in_ready, 1);
    chk("rst.out", {bus.out_valid, bus.result}, 9'h000);
    chk("rst.flags", {bus.zero, bus.overflow, bus.carry}, 3'b100);
    rst_n = 1'b1;
    @(negedge clk);

    run("add7f",  3'b010, 8'h7F, 8'h01, 1, 8'h80, 0, 1, 0);
    run("addff",  3'b010, 8'hFF, 8'h01, 1, 8'h00, 1, 0, 1);
    run("sub55",  3'b110, 8'h05, 8'h05, 1, 8'h00, 1, 0, 1);
    run("sub01",  3'b110, 8'h00, 8'h01, 1, 8'hFF, 0, 0, 0);
    run("sub80",  3'b110, 8'h80, 8'h01, 1, 8'h7F, 0, 1, 1);
    run("slt1",   3'b111, 8'h80, 8'h01, 1, 8'h01, 0, 0, 1);
    run("slt2",   3'b111, 8'h01, 8'h80, 1, 8'h00, 1, 0, 0);
    run("slt3",   3'b111, 8'h7F, 8'h80, 1, 8'h00, 1, 0, 0);
    run("and",    3'b000, 8'hF0, 8'h3C, 1, 8'h30, 0, 0, 0);
    run("or",     3'b001, 8'hF0, 8'h0F, 1, 8'hFF, 0, 0, 0);
    run("nor1",   3'b100, 8'h0F, 8'hF0, 1, 8'h00, 1, 0, 0);
    run("nor2",   3'b100, 8'h00, 8'h00, 1, 8'hFF, 0, 0, 0);
    run("rsv",    3'b101, 8'hAA, 8'h55, 1, 8'h00, 1, 0, 0);
    run("mul10",  3'b011, 8'h10, 8'h10, 9, 8'h00, 1, 1, 0);
    run("mul0f",  3'b011, 8'h0F, 8'h11, 9, 8'hFF, 0, 0, 0);
    run("mulff",  3'b011, 8'hFF, 8'hFF, 9, 8'h01, 0, 1, 0);

    // backpressure: result held, in_valid ignored while DONE
    bus.op = 3'b010;
    bus.src1 = 8'h12;
    bus.src2 = 8'h34;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("bp.valid", bus.out_valid, 1);
    bus.op = 3'b001;
    bus.src1 = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = (i != 1);
      @(negedge clk);
      chk("bp.hold", {bus.out_valid, bus.in_ready, bus.result}, 10'h246);
      chk("bp.flags", {bus.zero, bus.overflow, bus.carry}, 3'b000);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp.idle", {bus.out_valid, bus.in_ready}, 2'b01);
    @(negedge clk);
    chk("bp.noacc", {bus.out_valid, bus.in_ready}, 2'b01);

    // reset in the middle of a multiply
    bus.op = 3'b011;
    bus.src1 = 8'h0F;
    bus.src2 = 8'h11;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mr.busy", bus.in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mr.out", {bus.out_valid, bus.result}, 9'h000);
    chk("mr.rdy", {bus.in_ready, bus.zero}, 2'b11);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr.rel", bus.in_ready, 1);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid) pulses++;
    end
    chk("mr.nopulse", pulses, 0);
    run("add12",  3'b010, 8'h01, 8'h02, 1, 8'h03, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and result width in bits; legal range is 4..32.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous assertion, active-low, synchronous deassertion handled externally.
REQ-004 in_valid  input  1  SHALL mark that src1/src2/op are valid.
REQ-005 in_ready  output  1  SHALL mark that the block accepts an operation this cycle.
REQ-006 src1  input  WIDTH  SHALL be operand A.
REQ-007 src2  input  WIDTH  SHALL be operand B.
REQ-008 op  input  3  SHALL select the operation: 000 AND, 001 OR, 010 ADD, 011 MUL, 100 NOR, 110 SUB, 111 SLT, 101 reserved.
REQ-009 out_valid  output  1  SHALL mark that result and flags are valid.
REQ-010 out_ready  input  1  SHALL mark that the consumer takes the result this cycle.
REQ-011 result  output  WIDTH  SHALL be the registered operation result.
REQ-012 zero  output  1  SHALL be 1 iff result equals 0.
REQ-013 overflow  output  1  SHALL be the registered overflow flag.
REQ-014 carry  output  1  SHALL be the registered carry-out of the adder.

Function
REQ-015 Acceptance SHALL occur on a cycle with in_valid=1 and in_ready=1; src1, src2 and op SHALL be captured on that edge.
REQ-016 FSM SHALL have states IDLE, MUL, DONE; in_ready=1 only in IDLE.
REQ-017 IDLE, accept, op!=011 -> DONE with result/flags loaded on the same edge; out_valid=1 the next cycle (latency 1).
REQ-018 IDLE, accept, op=011 -> MUL; shift-add over WIDTH cycles, one multiplier bit per cycle, LSB first; after the last bit -> DONE; out_valid=1 exactly WIDTH+1 cycles after acceptance.
REQ-019 DONE SHALL hold result/zero/overflow/carry stable until out_valid&out_ready, then -> IDLE; no acceptance while in DONE.
REQ-020 ADD: result = (src1+src2) mod 2^WIDTH; carry = bit WIDTH of the sum; overflow = signed two's-complement overflow.
REQ-021 SUB: computed as src1 + ~src2 + 1; carry = adder carry-out (1 when no borrow); overflow = signed overflow.
REQ-022 SLT: result = 1 if signed src1 < signed src2 (sign of src1-src2 XOR overflow), else 0; overflow=0; carry = SUB carry.
REQ-023 AND/OR/NOR: bitwise; overflow=0, carry=0.
REQ-024 MUL: unsigned; result = low WIDTH bits of the 2*WIDTH product; overflow=1 iff the high WIDTH bits are nonzero; carry=0.
REQ-025 op=101: result=0, overflow=0, carry=0, zero=1, with latency 1.
REQ-026 in_valid while in_ready=0 SHALL be ignored, with no side effect.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state=IDLE, out_valid=0, result=0, overflow=0, carry=0, zero=1, and clear the multiplier datapath registers.
REQ-028 Reset during MUL or DONE SHALL abort the operation; no out_valid pulse SHALL follow; in_ready=1 on the first cycle after deassertion.
REQ-029 in_ready SHALL be 1 while in reset.

Verification (WIDTH=8)
REQ-030 ADD 0x7F+0x01 -> one cycle later out_valid=1, result=0x80, overflow=1, carry=0, zero=0.
REQ-031 SUB 0x05-0x05 -> result=0x00, zero=1, carry=1, overflow=0; SUB 0x00-0x01 -> 0xFF, carry=0.
REQ-032 SLT 0x80,0x01 -> result=0x01; SLT 0x01,0x80 -> 0x00; SLT 0x7F,0x80 -> 0x00.
REQ-033 MUL 0x10*0x10 -> out_valid exactly 9 cycles after acceptance, result=0x00, overflow=1, zero=1; MUL 0x0F*0x11 -> 0xFF, overflow=0.
REQ-034 Backpressure: hold out_ready=0 for 3 cycles in DONE -> result/flags unchanged, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-035 Assert rst_n=0 at cycle 4 of a MUL -> out_valid=0 immediately, result=0; after release, a new ADD 0x01+0x02 -> 0x03 with latency 1.
